// File: rtl/xifo_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the xifo queue adapters.
// No logic here; the enum encoding doubles as the reader's occupancy value.
// RD_SKID_DEPTH is the number of entries the stream reader can hold.
package xifo_pkg;

  localparam int RD_SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    RD_EMPTY = 2'd0,
    RD_HALF  = 2'd1,
    RD_FULL  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/xifo_fifo.sv
`timescale 1ns/1ps
// Generic show-ahead FIFO: head entry is visible on rd_dat whenever rd_empty is 0.
// Latency: a push at edge N is visible at the head after edge N (empty FIFO).
// Backpressure: pushes while full and pops while empty are ignored.
module xifo_fifo #(
  parameter int DWidth = 32,
  parameter int Depth  = 16
) (
  input  logic              core_clk,
  input  logic              arst_n,
  input  logic              wr_vld,
  input  logic [DWidth-1:0] wr_dat,
  output logic              wr_full,
  input  logic              rd_pop,
  output logic [DWidth-1:0] rd_dat,
  output logic              rd_empty
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DWidth-1:0] mem [Depth];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_wr;
  logic              do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign rd_empty = (wr_ptr == rd_ptr);
  assign wr_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_dat   = mem[rd_ptr[AW-1:0]];
  assign do_wr    = wr_vld && !wr_full;
  assign do_rd    = rd_pop && !rd_empty;

  // Advance read/write pointers on accepted operations.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge core_clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/xifo_stream_reader.sv
`timescale 1ns/1ps
// Pops a FIFO-mode queue into a 2-entry skid buffer and presents a registered valid/ready stream.
// Latency: entry popped at edge N is on m_data with m_valid=1 from edge N; one transfer per cycle.
// Backpressure: q_pop depends only on state, q_empty and flush; at most 2 pops while m_ready=0.
module xifo_stream_reader
  import xifo_pkg::*;
#(
  parameter int DWidth   = 32,
  parameter int CntWidth = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DWidth-1:0]   q_data,
  input  logic                q_empty,
  output logic                q_pop,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DWidth-1:0]   m_data,
  input  logic                flush,
  output logic [1:0]          occupancy,
  output logic [CntWidth-1:0] pop_count
);

  rd_state_e         state;
  rd_state_e         state_nxt;
  logic [DWidth-1:0] main_q;
  logic [DWidth-1:0] skid_q;
  logic              fire;
  logic              load_main_q;
  logic              load_main_skid;
  logic              load_skid;

  // Everything downstream-facing comes straight from registers.
  assign m_valid   = (state != RD_EMPTY);
  assign m_data    = main_q;
  assign occupancy = state;
  assign fire      = m_valid && m_ready;
  assign q_pop     = !q_empty && !flush && (state != RD_FULL);

  // Next state and data-register load selects; flush overrides everything.
  always_comb begin
    state_nxt      = state;
    load_main_q    = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = RD_EMPTY;
    end else begin
      case (state)
        RD_EMPTY: begin
          if (q_pop) begin
            state_nxt   = RD_HALF;
            load_main_q = 1'b1;
          end
        end
        RD_HALF: begin
          if (q_pop && fire) begin
            load_main_q = 1'b1;
          end else if (q_pop) begin
            state_nxt = RD_FULL;
            load_skid = 1'b1;
          end else if (fire) begin
            state_nxt = RD_EMPTY;
          end
        end
        RD_FULL: begin
          if (fire) begin
            state_nxt      = RD_HALF;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = RD_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RD_EMPTY;
    else     state <= state_nxt;
  end

  // Data registers: head entry in main_q, overflow entry parked in skid_q.
  always_ff @(posedge clk) begin
    if (load_main_q)         main_q <= q_data;
    else if (load_main_skid) main_q <= skid_q;
    if (load_skid)           skid_q <= q_data;
  end

  // Free-running pop statistic, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        pop_count <= '0;
    else if (q_pop) pop_count <= pop_count + CntWidth'(1);
  end

endmodule

// File: doc/xifo_stream_reader.md
# xifo_stream_reader

Consumer-side adapter for the generic queue primitive's pop interface. It pops entries whenever the queue is non-empty and internal space exists, then presents them downstream as a registered valid/ready stream through a 2-entry skid buffer. It sustains one transfer per cycle and has no combinational path from `m_ready` to `q_pop`. It sits between any FIFO-mode queue and a pipeline stage that applies backpressure.

## Interface
- `DWidth`, default 32: entry width in bits; must match the attached queue.
- `CntWidth`, default 16: width of the `pop_count` statistic counter.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `q_data` input, DWidth bits: queue head entry; valid whenever `q_empty`=0.
- `q_empty` input, 1 bit: queue empty flag.
- `q_pop` output, 1 bit: pop request to the queue.
- `m_valid` output, 1 bit: downstream data valid.
- `m_ready` input, 1 bit: downstream ready.
- `m_data` output, DWidth bits: downstream data.
- `flush` input, 1 bit: synchronous discard of buffered entries.
- `occupancy` output, 2 bits: entries held in the buffer (0..2).
- `pop_count` output, CntWidth bits: total pops since reset; wraps.

## Operation
- Storage:
  - `main_q` drives `m_data`.
  - `skid_q` holds the second entry.
  - State comes from package enum `rd_state_e`: RD_EMPTY (0 entries), RD_HALF (1), RD_FULL (2).
- Pop rule: `q_pop = !q_empty && !flush && (state != RD_FULL)`. It depends only on state, `q_empty` and `flush`, never on `m_ready`.
- Popped data is `q_data` sampled at the same clock edge on which `q_pop` is high.
- Fire: `fire = m_valid && m_ready`.
- `m_valid = (state != RD_EMPTY)`, taken from a registered state. `m_data = main_q`.
- Transitions (when `flush`=0):
  - RD_EMPTY: pop → RD_HALF; `main_q` ← `q_data`.
  - RD_HALF:
    - pop and fire → RD_HALF; `main_q` ← `q_data`.
    - pop and no fire → RD_FULL; `skid_q` ← `q_data`.
    - fire and no pop → RD_EMPTY.
    - otherwise hold.
  - RD_FULL: fire → RD_HALF; `main_q` ← `skid_q`. No pop is possible in RD_FULL.
- Flush:
  - Highest priority. The next state is RD_EMPTY and `q_pop` is 0 in that cycle.
  - A handshake in the flush cycle still counts as a transfer downstream.
  - Queue contents are untouched.
- `pop_count` increments on every `q_pop`=1 cycle and wraps modulo 2^CntWidth.
- `occupancy` encodes the state as 0, 1 or 2.
- Data registers have no reset requirement. Control registers and counters are reset.

## Timing
- Reset values: `m_valid`=0, `occupancy`=0, `pop_count`=0, state RD_EMPTY.
  - `q_pop` follows its comb rule, so with `q_empty`=0 it is 1 immediately after reset deassertion.
  - `m_data` is undefined until the first pop.
- Latency: an entry popped at edge N is on `m_data` with `m_valid`=1 from edge N until consumed. That is 1 cycle from `q_pop` high to `m_valid` high.
- Throughput: with `m_ready` held at 1 and the queue non-empty, the block stays in RD_HALF with one pop and one fire per cycle.
- Backpressure: with `m_ready`=0, at most 2 pops occur, then `q_pop` drops.
- Held data: while `m_valid`=1 and `m_ready`=0, `m_data` is stable.
- Ordering: the output order equals the pop order; there is no duplication or loss except by `flush`.
- Queue drains mid-burst (`q_empty` rises): buffered entries still deliver, and `q_pop` is 0.
- Reset mid-operation: state and counters clear asynchronously and buffered entries are lost. The queue must share the reset event; the integrating top drives the queue's active-low reset from `~rst`.

## Structure
- Shared package `xifo_pkg` holds:
  - `rd_state_e` (RD_EMPTY, RD_HALF, RD_FULL);
  - constant `RD_SKID_DEPTH` = 2.
- There is no sub-module: the skid buffer is two registers plus a 3-state FSM in one module.
- The bench instantiates the generic queue primitive in FIFO mode, depth 16, as the source.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 into the queue with `m_ready`=1 → `m_data` shows 0x11, 0x22, 0x33 on consecutive cycles; `pop_count`=3; `occupancy` returns to 0.
- Queue holds 5 entries and `m_ready`=0 → exactly 2 pops, `occupancy`=2, `q_pop`=0, `m_data` stable at the first entry. Then `m_ready`=1 → remaining entries delivered in order, one per cycle, no gaps.
- `m_ready` toggles 1,0,1,0 while 8 entries stream → all 8 delivered in order and `pop_count`=8.
- RD_FULL with `flush`=1 for one cycle → next cycle `m_valid`=0, `occupancy`=0, and `q_pop`=0 during the flush cycle. The next queue entry then arrives normally.
- Assert `rst` while in RD_FULL → outputs immediately `m_valid`=0, `occupancy`=0, `pop_count`=0.
- `CntWidth`=4, 17 pops → `pop_count` reads 1 (wrap).
